// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - five-phase instruction sequencer with PC, memory handshakes and timeout fault
module phase_sequencer #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          WAIT_LIMIT = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        run,
    input  logic        step,
    input  logic        memReady,
    input  logic        isMem,
    input  logic        isHalt,
    input  logic        isBranch,
    input  logic        branchCond,
    input  logic [15:0] execOut,
    input  logic        wbEnable,
    output logic [15:0] PC,
    output logic        fetchReq,
    output logic        irLoad,
    output logic        regRead,
    output logic        execValid,
    output logic        memReq,
    output logic        regWrite,
    output logic        flagWrite,
    output logic [2:0]  phase,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_HALTED = 3'd0,
        S_P1     = 3'd1,
        S_P2     = 3'd2,
        S_P3     = 3'd3,
        S_P4     = 3'd4,
        S_P5     = 3'd5,
        S_FAULT  = 3'd7
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] target_q, target_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        step_q, step_d;
    logic        mem_q, mem_d;
    logic        halt_q, halt_d;
    logic        branch_q, branch_d;
    logic        taken_q, taken_d;

    // Output flops hold the decode of the state the machine is in.
    logic fetch_req_q, fetch_req_d;
    logic reg_read_q, reg_read_d;
    logic exec_valid_q, exec_valid_d;
    logic mem_req_q, mem_req_d;
    logic wb_phase_q, wb_phase_d;
    logic halted_q, halted_d;
    logic fault_q, fault_d;

    // Next-state, latch and PC computation; outputs are decoded from the next state.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        target_d   = target_q;
        wait_cnt_d = wait_cnt_q;
        step_d     = step_q;
        mem_d      = mem_q;
        halt_d     = halt_q;
        branch_d   = branch_q;
        taken_d    = taken_q;

        case (state_q)
            S_HALTED: begin
                if (run) begin
                    state_d = S_P1;
                    step_d  = step;
                end
            end
            S_P1: begin
                if (memReady) begin
                    state_d = S_P2;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_P2: begin
                mem_d    = isMem;
                halt_d   = isHalt;
                branch_d = isBranch;
                state_d  = S_P3;
            end
            S_P3: begin
                if (branch_q && branchCond) begin
                    target_d = execOut;
                    taken_d  = 1'b1;
                end
                state_d = S_P4;
            end
            S_P4: begin
                if (!mem_q || memReady) begin
                    state_d = S_P5;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_P5: begin
                pc_d     = taken_q ? target_q : pc_q + 16'd1;
                state_d  = (halt_q || step_q) ? S_HALTED : S_P1;
                halt_d   = 1'b0;
                branch_d = 1'b0;
                taken_d  = 1'b0;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase

        // Every phase starts with a fresh wait budget.
        if (state_d != state_q) begin
            wait_cnt_d = 8'd0;
        end

        fetch_req_d  = (state_d == S_P1);
        reg_read_d   = (state_d == S_P2);
        exec_valid_d = (state_d == S_P3);
        mem_req_d    = (state_d == S_P4) && mem_d;
        wb_phase_d   = (state_d == S_P5);
        halted_d     = (state_d == S_HALTED);
        fault_d      = (state_d == S_FAULT);
    end

    // State, latches and registered outputs; reset aborts any instruction in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_HALTED;
            pc_q         <= RESET_PC;
            target_q     <= 16'h0000;
            wait_cnt_q   <= 8'd0;
            step_q       <= 1'b0;
            mem_q        <= 1'b0;
            halt_q       <= 1'b0;
            branch_q     <= 1'b0;
            taken_q      <= 1'b0;
            fetch_req_q  <= 1'b0;
            reg_read_q   <= 1'b0;
            exec_valid_q <= 1'b0;
            mem_req_q    <= 1'b0;
            wb_phase_q   <= 1'b0;
            halted_q     <= 1'b1;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            target_q     <= target_d;
            wait_cnt_q   <= wait_cnt_d;
            step_q       <= step_d;
            mem_q        <= mem_d;
            halt_q       <= halt_d;
            branch_q     <= branch_d;
            taken_q      <= taken_d;
            fetch_req_q  <= fetch_req_d;
            reg_read_q   <= reg_read_d;
            exec_valid_q <= exec_valid_d;
            mem_req_q    <= mem_req_d;
            wb_phase_q   <= wb_phase_d;
            halted_q     <= halted_d;
            fault_q      <= fault_d;
        end
    end

    assign PC        = pc_q;
    assign phase     = state_q;
    assign fetchReq  = fetch_req_q;
    assign irLoad    = fetch_req_q & memReady;
    assign regRead   = reg_read_q;
    assign execValid = exec_valid_q;
    assign flagWrite = exec_valid_q;
    assign memReq    = mem_req_q;
    assign regWrite  = wb_phase_q & wbEnable;
    assign halted    = halted_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - directed self-checking bench for phase_sequencer
module tb_phase_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        run, step, memReady, isMem, isHalt, isBranch, branchCond, wbEnable;
    logic [15:0] execOut;
    logic [15:0] PC;
    logic        fetchReq, irLoad, regRead, execValid, memReq, regWrite, flagWrite;
    logic [2:0]  phase;
    logic        halted, fault;

    int n_checks = 0;
    int n_fails  = 0;
    int ev_cnt;
    int mr_cnt;
    int rw_cnt;

    always #5 clock = ~clock;

    phase_sequencer #(.RESET_PC(16'h0000), .WAIT_LIMIT(4)) dut (
        .clock(clock), .reset_n(reset_n), .run(run), .step(step),
        .memReady(memReady), .isMem(isMem), .isHalt(isHalt), .isBranch(isBranch),
        .branchCond(branchCond), .execOut(execOut), .wbEnable(wbEnable),
        .PC(PC), .fetchReq(fetchReq), .irLoad(irLoad), .regRead(regRead),
        .execValid(execValid), .memReq(memReq), .regWrite(regWrite),
        .flagWrite(flagWrite), .phase(phase), .halted(halted), .fault(fault)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_to_pc(input logic [15:0] target);
        int k;
        k = 0;
        while (!(phase == 3'd1 && PC == target) && k < 600) begin
            tick();
            k++;
        end
        chk("reach_phase", 16'(phase), 16'd1);
        chk("reach_pc", PC, target);
    endtask

    initial begin
        reset_n = 1'b0; run = 1'b0; step = 1'b0; memReady = 1'b0; isMem = 1'b0;
        isHalt = 1'b0; isBranch = 1'b0; branchCond = 1'b0; execOut = 16'h0000; wbEnable = 1'b0;
        tick();
        tick();
        chk("rst_phase", 16'(phase), 16'd0);
        chk("rst_halted", 16'(halted), 16'd1);
        chk("rst_pc", PC, 16'h0000);
        chk("rst_fault", 16'(fault), 16'd0);
        chk("rst_fetch", 16'(fetchReq), 16'd0);
        chk("rst_exec", 16'(execValid), 16'd0);
        chk("rst_regwr", 16'(regWrite), 16'd0);

        reset_n = 1'b1;
        tick();
        chk("idle_halted", 16'(phase), 16'd0);

        // Free run, memory always ready.
        memReady = 1'b1; run = 1'b1;
        tick();
        run = 1'b0;
        chk("run_irload", 16'(irLoad), 16'd1);
        ev_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            for (int p = 1; p <= 5; p++) begin
                chk("seq_phase", 16'(phase), 16'(p));
                if (p == 1) chk("seq_pc", PC, 16'(i));
                if (p == 3) chk("seq_flagwr", 16'(flagWrite), 16'd1);
                if (execValid) ev_cnt++;
                tick();
            end
        end
        chk("seq_exec_pulses", 16'(ev_cnt), 16'd3);

        // Branch taken 0x10 -> 0x40, back to 0x10, then not taken -> 0x11.
        run_to_pc(16'h0010);
        isBranch = 1'b1; branchCond = 1'b1; execOut = 16'h0040;
        repeat (5) tick();
        chk("br_taken_phase", 16'(phase), 16'd1);
        chk("br_taken_pc", PC, 16'h0040);
        execOut = 16'h0010;
        repeat (5) tick();
        chk("br_back_pc", PC, 16'h0010);
        branchCond = 1'b0; execOut = 16'h0040;
        repeat (5) tick();
        chk("br_not_taken_pc", PC, 16'h0011);
        isBranch = 1'b0;

        // Load with three wait cycles in P4.
        isMem = 1'b1; wbEnable = 1'b1; mr_cnt = 0; rw_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            memReady = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
            #1;
            if (memReq) mr_cnt++;
            if (regWrite) rw_cnt++;
            tick();
        end
        chk("ld_phase", 16'(phase), 16'd1);
        chk("ld_pc", PC, 16'h0012);
        chk("ld_memreq_cycles", 16'(mr_cnt), 16'd4);
        chk("ld_regwrite_pulses", 16'(rw_cnt), 16'd1);
        isMem = 1'b0; wbEnable = 1'b0; memReady = 1'b1;

        // PC wrap: branch to 0xFFFF, then plain instruction.
        isBranch = 1'b1; branchCond = 1'b1; execOut = 16'hFFFF;
        repeat (5) tick();
        chk("wrap_at_ffff", PC, 16'hFFFF);
        isBranch = 1'b0; branchCond = 1'b0;
        repeat (5) tick();
        chk("wrap_to_zero", PC, 16'h0000);

        // HLT at PC 5 retires then halts; restart resumes at 6.
        run_to_pc(16'h0005);
        isHalt = 1'b1;
        repeat (5) tick();
        chk("hlt_phase", 16'(phase), 16'd0);
        chk("hlt_halted", 16'(halted), 16'd1);
        chk("hlt_pc", PC, 16'h0006);
        isHalt = 1'b0;
        tick();
        chk("hlt_stays", 16'(phase), 16'd0);
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("restart_phase", 16'(phase), 16'd1);
        chk("restart_pc", PC, 16'h0006);
        isHalt = 1'b1;
        repeat (5) tick();
        chk("hlt2_pc", PC, 16'h0007);
        isHalt = 1'b0;

        // Single step; run during P3 is ignored.
        run = 1'b1; step = 1'b1;
        tick();
        run = 1'b0; step = 1'b0;
        chk("step_phase", 16'(phase), 16'd1);
        ev_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            run = (c == 2) ? 1'b1 : 1'b0;
            if (execValid) ev_cnt++;
            tick();
        end
        run = 1'b0;
        chk("step_halted", 16'(halted), 16'd1);
        chk("step_pc", PC, 16'h0008);
        chk("step_exec_pulses", 16'(ev_cnt), 16'd1);
        tick();
        chk("step_stays", 16'(phase), 16'd0);

        // Fetch timeout with WAIT_LIMIT=4.
        memReady = 1'b0; run = 1'b1;
        tick();
        run = 1'b0;
        chk("to_p1", 16'(phase), 16'd1);
        repeat (3) tick();
        chk("to_not_yet", 16'(phase), 16'd1);
        tick();
        chk("to_phase", 16'(phase), 16'd7);
        chk("to_fault", 16'(fault), 16'd1);
        chk("to_pc", PC, 16'h0008);
        chk("to_fetch_off", 16'(fetchReq), 16'd0);
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("to_run_ignored", 16'(phase), 16'd7);
        reset_n = 1'b0;
        #1;
        chk("to_rst_phase", 16'(phase), 16'd0);
        chk("to_rst_halted", 16'(halted), 16'd1);
        chk("to_rst_pc", PC, 16'h0000);
        chk("to_rst_fault", 16'(fault), 16'd0);
        reset_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
